// File: rtl/round_controller.sv
// Round and score controller for the light-cycle game.
// Tracks survivors, awards round points, times the flash interval, declares the winner.
module round_controller #(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int FLASH_FRAMES = 125
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic                           serve,
    input  logic [NUM_PLAYERS-1:0]         crash,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [1:0]                     state,
    output logic                           run,
    output logic                           flash,
    output logic [2:0]                     winner,
    output logic                           winner_valid,
    output logic                           game_over
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLASH = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t           cur;
    logic [CNT_W-1:0] flash_cnt;

    logic [NUM_PLAYERS-1:0] next_alive;
    logic [3:0]             live_cnt;
    logic [2:0]             survivor;
    logic                   any_win;

    // Survivors after this cycle's crashes: how many, and which one if only one.
    always_comb begin
        next_alive = alive & ~crash;
        live_cnt   = 4'd0;
        survivor   = 3'd0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (next_alive[i]) begin
                live_cnt = live_cnt + 4'd1;
                survivor = 3'(i);
            end
        end
    end

    // Game ends once any player has reached the winning score.
    always_comb begin
        any_win = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (scores[i*SCORE_W +: SCORE_W] == WIN_VAL) begin
                any_win = 1'b1;
            end
        end
    end

    // Round FSM with registered alive mask, scores, winner and flash timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur          <= IDLE;
            alive        <= '1;
            scores       <= '0;
            winner       <= 3'd0;
            winner_valid <= 1'b0;
            flash_cnt    <= '0;
        end else begin
            unique case (cur)
                IDLE: begin
                    if (serve) begin
                        cur          <= RUN;
                        alive        <= '1;
                        winner_valid <= 1'b0;
                    end
                end
                RUN: begin
                    alive <= next_alive;
                    if (live_cnt <= 4'd1) begin
                        cur       <= FLASH;
                        flash_cnt <= '0;
                        if (live_cnt == 4'd1) begin
                            winner       <= survivor;
                            winner_valid <= 1'b1;
                            for (int i = 0; i < NUM_PLAYERS; i++) begin
                                if (survivor == 3'(i)) begin
                                    scores[i*SCORE_W +: SCORE_W] <=
                                        scores[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
                                end
                            end
                        end else begin
                            winner_valid <= 1'b0;
                        end
                    end
                end
                FLASH: begin
                    if (frame_tick) begin
                        if (flash_cnt == CNT_LAST) begin
                            cur <= any_win ? OVER : IDLE;
                        end else begin
                            flash_cnt <= flash_cnt + CNT_W'(1);
                        end
                    end
                end
                OVER: begin
                end
            endcase
        end
    end

    assign state     = cur;
    assign run       = (cur == RUN);
    assign flash     = (cur == FLASH);
    assign game_over = (cur == OVER);

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: vector table through a scoreboard queue,
// two instances (default 2-player and a small 4-player configuration).
module tb_round_controller;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_R = 2'd1;
    localparam logic [1:0] S_F = 2'd2;
    localparam logic [1:0] S_O = 2'd3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       r2 = 1'b1, s2 = 1'b0, t2 = 1'b0;
    logic [1:0] c2 = 2'b00;
    logic [1:0] alive2;
    logic [7:0] scores2;
    logic [1:0] st2;
    logic       run2, fl2, go2, wv2;
    logic [2:0] w2;

    logic        r4 = 1'b1, s4 = 1'b0, t4 = 1'b0;
    logic [3:0]  c4 = 4'b0000;
    logic [3:0]  alive4;
    logic [15:0] scores4;
    logic [1:0]  st4;
    logic        run4, fl4, go4, wv4;
    logic [2:0]  w4;

    round_controller dut2 (
        .clock(clock), .reset(r2), .frame_tick(t2), .serve(s2), .crash(c2),
        .alive(alive2), .scores(scores2), .state(st2), .run(run2), .flash(fl2),
        .winner(w2), .winner_valid(wv2), .game_over(go2)
    );

    round_controller #(
        .NUM_PLAYERS(4), .SCORE_W(4), .WIN_SCORE(2), .FLASH_FRAMES(3)
    ) dut4 (
        .clock(clock), .reset(r4), .frame_tick(t4), .serve(s4), .crash(c4),
        .alive(alive4), .scores(scores4), .state(st4), .run(run4), .flash(fl4),
        .winner(w4), .winner_valid(wv4), .game_over(go4)
    );

    typedef struct {
        bit          sel4;
        bit          rst;
        bit          srv;
        bit          tk;
        logic [3:0]  cr;
        logic [1:0]  st;
        logic [3:0]  al;
        logic [15:0] sc;
        logic [2:0]  w;
        bit          wv;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] sc2(input int a, input int b);
        return {8'h00, 4'(b), 4'(a)};
    endfunction

    function automatic logic [15:0] sc4(input int a, input int b,
                                        input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic vec_t mk(input bit sel4, input bit rst, input bit srv,
                                input bit tk, input logic [3:0] cr,
                                input logic [1:0] st, input logic [3:0] al,
                                input logic [15:0] sc, input logic [2:0] w,
                                input bit wv);
        vec_t v;
        v.sel4 = sel4; v.rst = rst; v.srv = srv; v.tk = tk; v.cr = cr;
        v.st = st; v.al = al; v.sc = sc; v.w = w; v.wv = wv;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    // n counted ticks in FLASH; optional idle cycle after the first tick,
    // optional serve on the final tick; fst is the state after the final tick.
    task automatic add_flash(input bit sel4, input int n, input bit gap,
                             input bit srv_last, input logic [1:0] fst,
                             input logic [3:0] al, input logic [15:0] sc,
                             input logic [2:0] w, input bit wv);
        for (int k = 1; k <= n; k++) begin
            add(mk(sel4, 1'b0, srv_last && (k == n), 1'b1, 4'b0000,
                   (k == n) ? fst : S_F, al, sc, w, wv));
            if (gap && k == 1 && n > 1)
                add(mk(sel4, 1'b0, 1'b0, 1'b0, 4'b0000, S_F, al, sc, w, wv));
        end
    endtask

    task automatic check(input vec_t e, input int idx);
        logic [1:0]  st;
        logic [3:0]  al;
        logic [15:0] sc;
        logic [2:0]  w;
        logic        wv, rn, fl, go;
        if (e.sel4) begin
            st = st4; al = alive4; sc = scores4; w = w4;
            wv = wv4; rn = run4; fl = fl4; go = go4;
        end else begin
            st = st2; al = {2'b00, alive2}; sc = {8'h00, scores2}; w = w2;
            wv = wv2; rn = run2; fl = fl2; go = go2;
        end
        checks++;
        if ({st, al, sc, w, wv, rn, fl, go} !==
            {e.st, e.al, e.sc, e.w, e.wv,
             e.st == S_R, e.st == S_F, e.st == S_O}) begin
            errors++;
            $display("FAIL vec%0d dut%0d: got st=%0d alive=%b scores=%h w=%0d wv=%b run=%b flash=%b over=%b, want st=%0d alive=%b scores=%h w=%0d wv=%b",
                     idx, e.sel4 ? 4 : 2, st, al, sc, w, wv, rn, fl, go,
                     e.st, e.al, e.sc, e.w, e.wv);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clock);
        r2 = 1'b0; s2 = 1'b0; t2 = 1'b0; c2 = 2'b00;
        r4 = 1'b0; s4 = 1'b0; t4 = 1'b0; c4 = 4'b0000;
        if (v.sel4) begin
            r4 = v.rst; s4 = v.srv; t4 = v.tk; c4 = v.cr;
        end else begin
            r2 = v.rst; s2 = v.srv; t2 = v.tk; c2 = v.cr[1:0];
        end
        sb.push_back(v);
        @(posedge clock);
        #1;
        check(sb.pop_front(), idx);
    endtask

    initial begin
        // ---- two players, default parameters ----
        add(mk(0, 1, 0, 0, 4'b0000, S_I, 4'b0011, sc2(0, 0), 3'd0, 0));
        add(mk(0, 0, 0, 0, 4'b0011, S_I, 4'b0011, sc2(0, 0), 3'd0, 0));
        add(mk(0, 0, 1, 0, 4'b0000, S_R, 4'b0011, sc2(0, 0), 3'd0, 0));
        add(mk(0, 0, 1, 1, 4'b0000, S_R, 4'b0011, sc2(0, 0), 3'd0, 0));
        add(mk(0, 0, 0, 1, 4'b0010, S_F, 4'b0001, sc2(1, 0), 3'd0, 1));
        add(mk(0, 0, 1, 0, 4'b0011, S_F, 4'b0001, sc2(1, 0), 3'd0, 1));
        add_flash(0, 125, 0, 1, S_I, 4'b0001, sc2(1, 0), 3'd0, 1);
        add(mk(0, 0, 0, 0, 4'b0000, S_I, 4'b0001, sc2(1, 0), 3'd0, 1));
        add(mk(0, 0, 1, 0, 4'b0000, S_R, 4'b0011, sc2(1, 0), 3'd0, 0));
        add(mk(0, 0, 0, 0, 4'b0011, S_F, 4'b0000, sc2(1, 0), 3'd0, 0));
        add_flash(0, 125, 1, 0, S_I, 4'b0000, sc2(1, 0), 3'd0, 0);
        for (int r = 0; r < 9; r++) begin
            add(mk(0, 0, 1, 0, 4'b0000, S_R, 4'b0011, sc2(1, r),
                   (r == 0) ? 3'd0 : 3'd1, 0));
            add(mk(0, 0, 0, 0, 4'b0001, S_F, 4'b0010, sc2(1, r + 1), 3'd1, 1));
            add_flash(0, 125, r == 3, 0, (r == 8) ? S_O : S_I, 4'b0010,
                      sc2(1, r + 1), 3'd1, 1);
        end
        add(mk(0, 0, 1, 0, 4'b0000, S_O, 4'b0010, sc2(1, 9), 3'd1, 1));
        add(mk(0, 0, 1, 1, 4'b0011, S_O, 4'b0010, sc2(1, 9), 3'd1, 1));
        add(mk(0, 1, 1, 0, 4'b0000, S_I, 4'b0011, sc2(0, 0), 3'd0, 0));

        // ---- four players, WIN_SCORE=2, FLASH_FRAMES=3 ----
        add(mk(1, 1, 0, 0, 4'b0000, S_I, 4'b1111, sc4(0, 0, 0, 0), 3'd0, 0));
        add(mk(1, 0, 1, 0, 4'b0000, S_R, 4'b1111, sc4(0, 0, 0, 0), 3'd0, 0));
        add(mk(1, 0, 0, 0, 4'b0010, S_R, 4'b1101, sc4(0, 0, 0, 0), 3'd0, 0));
        add(mk(1, 0, 0, 0, 4'b0010, S_R, 4'b1101, sc4(0, 0, 0, 0), 3'd0, 0));
        add(mk(1, 0, 0, 0, 4'b0100, S_R, 4'b1001, sc4(0, 0, 0, 0), 3'd0, 0));
        add(mk(1, 0, 0, 0, 4'b1010, S_F, 4'b0001, sc4(1, 0, 0, 0), 3'd0, 1));
        add_flash(1, 3, 1, 0, S_I, 4'b0001, sc4(1, 0, 0, 0), 3'd0, 1);
        add(mk(1, 0, 1, 0, 4'b0000, S_R, 4'b1111, sc4(1, 0, 0, 0), 3'd0, 0));
        add(mk(1, 0, 0, 0, 4'b1011, S_F, 4'b0100, sc4(1, 0, 1, 0), 3'd2, 1));
        add_flash(1, 3, 0, 0, S_I, 4'b0100, sc4(1, 0, 1, 0), 3'd2, 1);
        add(mk(1, 0, 1, 0, 4'b0000, S_R, 4'b1111, sc4(1, 0, 1, 0), 3'd2, 0));
        add(mk(1, 0, 0, 0, 4'b0111, S_F, 4'b1000, sc4(1, 0, 1, 1), 3'd3, 1));
        add_flash(1, 3, 0, 0, S_I, 4'b1000, sc4(1, 0, 1, 1), 3'd3, 1);
        add(mk(1, 0, 1, 0, 4'b0000, S_R, 4'b1111, sc4(1, 0, 1, 1), 3'd3, 0));
        add(mk(1, 0, 0, 0, 4'b1011, S_F, 4'b0100, sc4(1, 0, 2, 1), 3'd2, 1));
        add_flash(1, 3, 1, 0, S_O, 4'b0100, sc4(1, 0, 2, 1), 3'd2, 1);
        add(mk(1, 0, 1, 1, 4'b1111, S_O, 4'b0100, sc4(1, 0, 2, 1), 3'd2, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // ---- reset mid-FLASH (counter at 60) with serve and crash high ----
        apply(mk(0, 0, 1, 0, 4'b0000, S_R, 4'b0011, sc2(0, 0), 3'd0, 0), 9000);
        apply(mk(0, 0, 0, 0, 4'b0010, S_F, 4'b0001, sc2(1, 0), 3'd0, 1), 9001);
        for (int k = 0; k < 60; k++) begin
            apply(mk(0, 0, 0, 1, 4'b0000, S_F, 4'b0001, sc2(1, 0), 3'd0, 1),
                  9100 + k);
        end
        apply(mk(0, 1, 1, 1, 4'b0011, S_I, 4'b0011, sc2(0, 0), 3'd0, 0), 9200);
        apply(mk(0, 0, 0, 0, 4'b0000, S_I, 4'b0011, sc2(0, 0), 3'd0, 0), 9201);
        apply(mk(0, 0, 1, 0, 4'b0000, S_R, 4'b0011, sc2(0, 0), 3'd0, 0), 9202);
        apply(mk(0, 0, 0, 0, 4'b0001, S_F, 4'b0010, sc2(0, 1), 3'd1, 1), 9203);
        for (int k = 1; k <= 125; k++) begin
            apply(mk(0, 0, 0, 1, 4'b0000, (k == 125) ? S_I : S_F, 4'b0010,
                     sc2(0, 1), 3'd1, 1), 9300 + k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_controller.md
# round_controller

Parametrised round and score controller for the light-cycle game. It tracks which of `NUM_PLAYERS` players are still alive during a round and awards a point to the last survivor. It then holds a frame-counted flash interval and declares a game winner at `WIN_SCORE`. It sits between the per-player movement/collision logic and the display and seven-segment paths, and generalises the fixed two-player score counters, win comparators and flash counter into one block.

## Interface
- `NUM_PLAYERS`, default 2: number of players, legal range 2..8.
- `SCORE_W`, default 4: width of each player's score.
- `WIN_SCORE`, default 9: score that ends the game; must be below 2^SCORE_W.
- `FLASH_FRAMES`, default 125: length of the post-round flash interval, counted in frame ticks; must be at least 1.
- `clock  in  1`: system clock (pixel clock domain).
- `reset  in  1`: synchronous, active-high; one clock; reset is synchronous and active-high.
- `frame_tick  in  1`: single-cycle pulse once per video frame.
- `serve  in  1`: synchronised serve request; level or pulse.
- `crash  in  NUM_PLAYERS`: bit i high means player i collided this cycle.
- `alive  out  NUM_PLAYERS`: players still in the current round.
- `scores  out  NUM_PLAYERS*SCORE_W`: player i's score is at `[i*SCORE_W +: SCORE_W]`.
- `state  out  2`: IDLE=0, RUN=1, FLASH=2, OVER=3.
- `run  out  1`: high in RUN; enables player movement.
- `flash  out  1`: high in FLASH.
- `winner  out  3`: index of the last round or game winner.
- `winner_valid  out  1`: the last completed round had a single survivor.
- `game_over  out  1`: high in OVER.

## Operation
- Reset values: state=IDLE, alive=all ones, scores=0, winner=0, winner_valid=0, flash counter=0, run=0, flash=0, game_over=0.
- IDLE
  - `serve`=1 moves the block to RUN, sets alive to all ones and clears winner_valid.
  - crash is ignored.
- RUN
  - Each cycle: alive <= alive & ~crash.
  - Crash bits of already-dead players have no effect.
  - Let `next_alive` = alive & ~crash. When popcount(`next_alive`) <= 1, the round ends and the block moves to FLASH.
  - Exactly one survivor k: scores[k] increments by 1, winner=k, winner_valid=1.
  - Zero survivors (all remaining players crash in the same cycle): draw; no score change, winner unchanged, winner_valid=0.
  - serve is ignored.
- FLASH
  - The flash counter clears on entry.
  - Each `frame_tick` observed while in FLASH increments the counter.
  - When a tick arrives with counter == FLASH_FRAMES-1, the block leaves FLASH. It goes to OVER if any score equals WIN_SCORE, otherwise to IDLE.
  - serve and crash are ignored.
- OVER
  - All outputs hold.
  - Only `reset` exits OVER.
- Scores never exceed WIN_SCORE, so no wrap is possible under legal parameters.
- Outputs run, flash and game_over are decoded from the registered state; all other outputs are registers.

## Timing
- serve sampled at cycle t in IDLE: state=RUN and alive=all ones at t+1.
- crash at cycle t in RUN: alive updated at t+1. If the crash ends the round, state=FLASH, the score and winner update, and run drops at t+1.
- A frame_tick coincident with the cycle that ends the round is not counted.
- FLASH lasts exactly FLASH_FRAMES counted ticks. The state change occurs one cycle after the final tick.
- serve in the same cycle as the FLASH→IDLE transition is ignored; serve must be seen while in IDLE.
- reset at any cycle, including mid-RUN or mid-FLASH: all registers take their reset values at the next edge, and reset dominates serve and crash.

## Test plan
- Reset, then serve with NUM_PLAYERS=2: state=RUN one cycle later, alive=2'b11, scores=0.
- RUN, crash=2'b10 for one cycle: next cycle alive=2'b01, state=FLASH, scores[0]=1, winner=0, winner_valid=1. After 125 frame_ticks, state=IDLE one cycle after the last tick.
- NUM_PLAYERS=4, crashes on players 1, 2 and 3 in separate cycles: state stays RUN until the third crash. Then player 0 scores and winner=0. A repeated crash on player 1 in between changes nothing.
- NUM_PLAYERS=2, crash=2'b11 in the same cycle: draw. Scores unchanged, winner_valid=0, state=FLASH, then IDLE.
- Player 1 wins 9 rounds (WIN_SCORE=9): after the 9th flash, state=OVER, game_over=1, winner=1, scores[1]=9. A later serve has no effect; reset returns state to IDLE with scores 0.
- reset asserted mid-FLASH (counter=60) with serve high: next cycle state=IDLE, counter=0, scores=0, serve not taken.
